mod_delay_line: RTL and testbench
=================================

// Module: mod_delay_line
// PURPOSE
//  LFO-modulated fractional delay line; the chorus/vibrato stage fed by the LFO generator.
//  Writes each 44.1 kHz audio sample into a circular buffer.
//  Reads one tap at delay = BASE_DELAY + scaled LFO value, with linear interpolation between adjacent samples.
//  Drives the wet signal toward the output mixer/FIFO.
// PARAMETERS
//  ADDR_W      10   buffer address width; DEPTH = 2**ADDR_W samples
//  FRAC_W      8    fractional delay bits (Q(ADDR_W).FRAC_W delay word)
//  BASE_DELAY  512  centre delay in whole samples; must lie in [1, DEPTH-2]
//  MOD_SHIFT   1    arithmetic right shift applied to lfo_i before adding; +-64 samples at defaults
// PORTS
//  clk_i           in   1   system clock
//  rst_n_i         in   1   asynchronous active-low reset
//  sample_i        in   16  signed audio input sample
//  sample_valid_i  in   1   1-cycle strobe, one per audio sample period
//  lfo_i           in   16  signed LFO value
//  lfo_valid_i     in   1   1-cycle strobe: new lfo_i value
//  sample_o        out  16  signed delayed/interpolated sample
//  sample_valid_o  out  1   1-cycle strobe: sample_o updated
//  busy_o          out  1   high while FSM not in IDLE
//  overrun_o       out  1   sticky: sample_valid_i arrived while busy
// BEHAVIOUR
//  Reset (async): sample_o=0, sample_valid_o=0, busy_o=0, overrun_o=0, FSM=IDLE, wr_ptr=0, fill=0, lfo_q=0.
//    Reset mid-operation aborts the sample; no output strobe is produced for it.
//  lfo_q <= lfo_i on every lfo_valid_i. An lfo_valid_i sampled on the same edge as sample_valid_i applies to that sample.
//  FSM: IDLE -> WRITE -> RD_A -> RD_B -> MULT -> OUT -> IDLE; one cycle per state after IDLE.
//    IDLE: on sample_valid_i, capture sample_i.
//    WRITE: RAM[wr_ptr] <= sample.
//      Compute dq = (BASE_DELAY<<FRAC_W) + (lfo_q>>>MOD_SHIFT), signed, width ADDR_W+FRAC_W+2.
//      Clamp: dq < 1<<FRAC_W -> 1.0; dq > (DEPTH-2)<<FRAC_W -> (DEPTH-2).0.
//      Split into d_int and d_frac.
//    RD_A: issue read addr A = wr_ptr - d_int (mod DEPTH); synchronous RAM, 1-cycle read.
//    RD_B: capture a; issue addr B = A-1 (mod DEPTH), the older neighbour.
//    MULT: capture b; register p = (b - a) * d_frac (17x FRAC_W signed, full width).
//    OUT: sample_o <= a + (p >>> FRAC_W); sample_valid_o=1; wr_ptr++ (wraps DEPTH-1 -> 0);
//      fill = min(fill+1, DEPTH).
//  Latency: sample_valid_o pulses exactly 5 clocks after the edge that samples sample_valid_i.
//  Result is convex in a,b; no saturation needed; truncation toward -inf.
//  Fill mask: any tap with age (d_int or d_int+1) > fill reads as 0, never stale RAM.
//  sample_valid_i while busy_o: ignored; overrun_o <= 1 until reset. Stored sample unaffected.
//  The read address never equals wr_ptr (d_int >= 1), so no RAM read/write collision.
// CONFIGURATION
//  MODDELAY_INTERP_EN defined: linear interpolation as above.
//  MODDELAY_INTERP_EN undefined: nearest tap; d_int += d_frac[FRAC_W-1], re-clamped to DEPTH-2.
//    RD_B/MULT still occupy one cycle each (latency stays 5); sample_o = a.
// STRUCTURE
//  moddelay_pkg: state_t enum, SAMPLE_W=16, LATENCY=5, delay word width function.
//  Sub-module moddelay_ram: simple dual-port sync RAM (1 write, 1 registered read), BRAM-inferable.
//    No reset on contents.
// TESTING
//  Impulse: BASE_DELAY=4, lfo=0, 0x4000 at sample 0, zeros after
//    -> output 0x4000 at output index 4 only; every sample_valid_o exactly 5 clks after input strobe.
//  Fractional: BASE_DELAY=4, lfo_i=256 (d=4.5), input ramp x[k]=100k
//    -> output index 10 = 550; steady slope 100/sample (interp build).
//  Clamp: BASE_DELAY=4, lfo_i=-32768 -> delay clamps to 1.0; output[k] = x[k-1].
//  Overrun: second sample_valid_i 2 clks after first
//    -> overrun_o=1 sticky; exactly one sample_valid_o; wr_ptr advances by 1.
//  Wrap/fill: ADDR_W=10, BASE_DELAY=512, lfo=0, 3000-sample ramp
//    -> first 512 outputs 0, then x[k-512] continuous across wr_ptr wrap at 1024 and 2048.
//  Reset mid-op: deassert rst_n_i while FSM in MULT
//    -> all outputs 0 immediately; no strobe; next sample writes address 0.

Source files
------------

// File: rtl/moddelay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : moddelay_pkg
//  Description : Shared types and constants for the LFO-modulated delay line.
//  Revision    : 1.0 - initial release
// ============================================================================
package moddelay_pkg;

   localparam int SAMPLE_W = 16;
   localparam int LATENCY  = 5;

   // Sequencer states: one cycle each after IDLE.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_RD_A  = 3'd2,
      ST_RD_B  = 3'd3,
      ST_MULT  = 3'd4,
      ST_OUT   = 3'd5
   } state_t;

   // Signed Q(addr_w).frac_w delay word with headroom for the LFO offset and sign.
   function automatic int delay_word_w(input int addr_w, input int frac_w);
      return addr_w + frac_w + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/moddelay_ram.sv
`default_nettype none
// ============================================================================
//  Module      : moddelay_ram
//  Description : Simple dual-port synchronous RAM, one write port and one
//                registered read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module moddelay_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int c_depth = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [c_depth];

   // Write port plus one-cycle registered read.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         r_mem[wr_addr_i] <= wr_data_i;
      end
      rd_data_o <= r_mem[rd_addr_i];
   end

endmodule
`default_nettype wire

// File: rtl/mod_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : mod_delay_line
//  Description : LFO-modulated fractional delay line (chorus/vibrato stage).
//                Each audio sample is written to a circular buffer and one tap
//                is read at BASE_DELAY + (lfo >>> MOD_SHIFT) samples.
//                Build option MODDELAY_INTERP_EN: linear interpolation between
//                adjacent taps; otherwise nearest tap.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_delay_line
   import moddelay_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int FRAC_W     = 8,
   parameter int BASE_DELAY = 512,
   parameter int MOD_SHIFT  = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic signed [SAMPLE_W-1:0] sample_i,
   input  logic                       sample_valid_i,
   input  logic signed [SAMPLE_W-1:0] lfo_i,
   input  logic                       lfo_valid_i,
   output logic signed [SAMPLE_W-1:0] sample_o,
   output logic                       sample_valid_o,
   output logic                       busy_o,
   output logic                       overrun_o
);

   localparam int c_depth = 2**ADDR_W;
   localparam int c_dw    = delay_word_w(ADDR_W, FRAC_W);

   localparam logic signed [c_dw-1:0] c_dq_base = c_dw'(BASE_DELAY << FRAC_W);
   localparam logic signed [c_dw-1:0] c_dq_min  = c_dw'(1 << FRAC_W);
   localparam logic signed [c_dw-1:0] c_dq_max  = c_dw'((c_depth - 2) << FRAC_W);
   localparam logic [ADDR_W:0]        c_fill_max = (ADDR_W+1)'(c_depth);

   state_t                      r_state, w_state_nxt;
   logic signed [SAMPLE_W-1:0]  r_lfo, r_sample, r_a, w_result;
   logic [ADDR_W-1:0]           r_wr_ptr, r_d_int, w_d_int, w_d_int_raw, w_rd_addr;
   logic [ADDR_W:0]             r_fill;
   logic                        r_mask_a;
   logic [SAMPLE_W-1:0]         w_rd_data;
   logic signed [SAMPLE_W-1:0]  w_lfo_sh;
   logic signed [c_dw-1:0]      w_dq, w_dq_c;

   // Delay word: centre delay plus scaled LFO, clamped so both taps stay inside the buffer.
   assign w_lfo_sh    = r_lfo >>> MOD_SHIFT;
   assign w_dq        = c_dq_base + c_dw'(w_lfo_sh);
   assign w_dq_c      = (w_dq < c_dq_min) ? c_dq_min :
                        (w_dq > c_dq_max) ? c_dq_max : w_dq;
   assign w_d_int_raw = ADDR_W'(w_dq_c >>> FRAC_W);

   // Newer tap in RD_A, its older neighbour one address back in RD_B.
   assign w_rd_addr = (r_state == ST_RD_B) ? (r_wr_ptr - r_d_int - ADDR_W'(1))
                                           : (r_wr_ptr - r_d_int);

`ifdef MODDELAY_INTERP_EN
   logic [FRAC_W-1:0]                 w_d_frac, r_d_frac;
   logic                              r_mask_b;
   logic signed [SAMPLE_W-1:0]        w_b;
   logic signed [SAMPLE_W:0]          w_diff;
   logic signed [SAMPLE_W+FRAC_W+1:0] w_prod, r_p, w_sum;

   assign w_d_int  = w_d_int_raw;
   assign w_d_frac = FRAC_W'(w_dq_c);
   assign w_b      = r_mask_b ? '0 : w_rd_data;
   assign w_diff   = (SAMPLE_W+1)'(w_b) - (SAMPLE_W+1)'(r_a);
   assign w_prod   = w_diff * $signed({1'b0, r_d_frac});
   // Result is a convex mix of a and b, so it always fits; >>> floors toward -inf.
   assign w_sum    = (SAMPLE_W+FRAC_W+2)'(r_a) + (r_p >>> FRAC_W);
   assign w_result = SAMPLE_W'(w_sum);

   // Fraction weight, older-tap mask and the registered interpolation product.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_d_frac <= '0;
         r_mask_b <= 1'b0;
         r_p      <= '0;
      end else begin
         if (r_state == ST_WRITE) begin
            r_d_frac <= w_d_frac;
            r_mask_b <= (({1'b0, w_d_int} + (ADDR_W+1)'(1)) > r_fill);
         end
         if (r_state == ST_MULT) begin
            r_p <= w_prod;
         end
      end
   end
`else
   localparam logic [ADDR_W-1:0] c_d_max = ADDR_W'(c_depth - 2);
   logic [ADDR_W-1:0] w_d_near;

   // Round to nearest whole tap, then keep within the buffer again.
   assign w_d_near = w_d_int_raw + ADDR_W'(w_dq_c[FRAC_W-1]);
   assign w_d_int  = (w_d_near > c_d_max) ? c_d_max : w_d_near;
   assign w_result = r_a;
`endif

   moddelay_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (SAMPLE_W)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (r_state == ST_WRITE),
      .wr_addr_i (r_wr_ptr),
      .wr_data_i (r_sample),
      .rd_addr_i (w_rd_addr),
      .rd_data_o (w_rd_data)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state sequencing and busy indication.
   always_comb begin
      w_state_nxt = r_state;
      busy_o      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (sample_valid_i) begin
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: w_state_nxt = ST_RD_A;
         ST_RD_A:  w_state_nxt = ST_RD_B;
         ST_RD_B:  w_state_nxt = ST_MULT;
         ST_MULT:  w_state_nxt = ST_OUT;
         ST_OUT:   w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Sample capture, tap selection, output and buffer bookkeeping.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_lfo          <= '0;
         r_sample       <= '0;
         r_wr_ptr       <= '0;
         r_fill         <= '0;
         r_d_int        <= '0;
         r_mask_a       <= 1'b0;
         r_a            <= '0;
         sample_o       <= '0;
         sample_valid_o <= 1'b0;
         overrun_o      <= 1'b0;
      end else begin
         sample_valid_o <= 1'b0;
         if (lfo_valid_i) begin
            r_lfo <= lfo_i;
         end
         if (sample_valid_i && busy_o) begin
            overrun_o <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (sample_valid_i) begin
                  r_sample <= sample_i;
               end
            end
            ST_WRITE: begin
               r_d_int  <= w_d_int;
               // Taps older than the samples written since reset read as silence.
               r_mask_a <= ({1'b0, w_d_int} > r_fill);
            end
            ST_RD_B: begin
               r_a <= r_mask_a ? '0 : w_rd_data;
            end
            ST_OUT: begin
               sample_o       <= w_result;
               sample_valid_o <= 1'b1;
               r_wr_ptr       <= r_wr_ptr + ADDR_W'(1);
               if (r_fill != c_fill_max) begin
                  r_fill <= r_fill + (ADDR_W+1)'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mod_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_delay_line
//  Description : Directed self-checking bench for mod_delay_line. One instance
//                at BASE_DELAY=4 for tap tests, one at BASE_DELAY=512 for the
//                fill/wrap test. Expectations follow MODDELAY_INTERP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_delay_line;
   import moddelay_pkg::*;

   logic                       clk_i = 1'b0;
   logic                       rst_n_i;
   logic signed [SAMPLE_W-1:0] sample_i;
   logic                       sample_valid_i;
   logic signed [SAMPLE_W-1:0] lfo_i;
   logic                       lfo_valid_i;

   logic signed [SAMPLE_W-1:0] so4, so512;
   logic                       sv4, sv512, busy4, busy512, ovr4, ovr512;

   int n_checks = 0;
   int n_errors = 0;
   int lat_bad  = 0;
   int o4, o512, pulses, errs_zero, errs_body, expv;
   int res [12];
   int s1024, s2048, slast, s511, s512;

   mod_delay_line #(.ADDR_W(10), .FRAC_W(8), .BASE_DELAY(4), .MOD_SHIFT(1)) u_dut4 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
      .lfo_i(lfo_i), .lfo_valid_i(lfo_valid_i), .sample_o(so4), .sample_valid_o(sv4),
      .busy_o(busy4), .overrun_o(ovr4));

   mod_delay_line #(.ADDR_W(10), .FRAC_W(8), .BASE_DELAY(512), .MOD_SHIFT(1)) u_dut512 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
      .lfo_i(lfo_i), .lfo_valid_i(lfo_valid_i), .sample_o(so512), .sample_valid_o(sv512),
      .busy_o(busy512), .overrun_o(ovr512));

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_n_i        = 1'b0;
      sample_valid_i = 1'b0;
      lfo_valid_i    = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
   endtask

   // One sample through both instances; flags any strobe/busy timing deviation.
   task automatic send(input int x, input bit lfo_en, input int lfo, output int r4, output int r512);
      @(negedge clk_i);
      sample_i       = SAMPLE_W'(x);
      sample_valid_i = 1'b1;
      if (lfo_en) begin
         lfo_i       = SAMPLE_W'(lfo);
         lfo_valid_i = 1'b1;
      end
      @(posedge clk_i); #1;
      sample_valid_i = 1'b0;
      lfo_valid_i    = 1'b0;
      if (sv4 !== 1'b0 || sv512 !== 1'b0 || busy4 !== 1'b1) lat_bad++;
      for (int i = 1; i <= LATENCY; i++) begin
         @(posedge clk_i); #1;
         if (sv4 !== (i == LATENCY) || sv512 !== (i == LATENCY)) lat_bad++;
         if (busy4 !== (i < LATENCY)) lat_bad++;
      end
      r4   = so4;
      r512 = so512;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n_i = 1'b0; sample_i = '0; sample_valid_i = 1'b0; lfo_i = '0; lfo_valid_i = 1'b0;
      repeat (3) @(posedge clk_i); #1;
      check("rst_sample_o", so4, 0);
      check("rst_valid", sv4, 0);
      check("rst_busy", busy4, 0);
      check("rst_overrun", ovr4, 0);
      @(negedge clk_i); rst_n_i = 1'b1;

      // Impulse at d=4.
      lat_bad = 0;
      for (int k = 0; k < 10; k++) begin
         send((k == 0) ? 16384 : 0, 1'b0, 0, o4, o512);
         check($sformatf("imp_%0d", k), o4, (k == 4) ? 16384 : 0);
      end
      check("imp_latency", lat_bad, 0);

      // Ramp 100k at d=4.5, LFO applied with the first sample.
      do_reset();
      for (int k = 0; k < 12; k++) begin
         send(100 * k, k == 0, 256, o4, o512);
         res[k] = o4;
      end
`ifdef MODDELAY_INTERP_EN
      check("frac_10", res[10], 550);
      check("frac_7", res[7], 250);
`else
      check("frac_10", res[10], 500);
      check("frac_7", res[7], 200);
`endif
      check("frac_4", res[4], 0);
      check("frac_slope", res[11] - res[10], 100);

      // Ramp 37k at d=4.25: negative step -9.25 floors to -10.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         send(37 * k, k == 0, 128, o4, o512);
         res[k] = o4;
      end
`ifdef MODDELAY_INTERP_EN
      check("floor_8", res[8], 138);
      check("floor_5", res[5], 27);
`else
      check("floor_8", res[8], 148);
      check("floor_5", res[5], 37);
`endif

      // d=4, then LFO -32768 on sample 6's edge clamps to d=1.0.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         send(50 - 300 * k, k == 6, -32768, o4, o512);
         res[k] = o4;
      end
      check("clamp_3", res[3], 0);
      check("clamp_4", res[4], 50);
      check("clamp_5", res[5], -250);
      check("clamp_6", res[6], -1450);
      check("clamp_9", res[9], -2350);

      // Overrun: second strobe two clocks after the first is dropped.
      do_reset();
      lat_bad = 0;
      @(negedge clk_i); sample_i = 16'sd1000; sample_valid_i = 1'b1;
      @(posedge clk_i); #1; sample_valid_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i); sample_i = 16'sd2000; sample_valid_i = 1'b1;
      @(posedge clk_i); #1; sample_valid_i = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i); #1;
         if (sv4 === 1'b1) pulses++;
      end
      check("ovr_pulses", pulses, 1);
      check("ovr_flag", ovr4, 1);
      for (int k = 1; k <= 4; k++) begin
         send(0, 1'b0, 0, o4, o512);
         res[k] = o4;
      end
      check("ovr_tap3", res[3], 0);
      check("ovr_tap4", res[4], 1000);
      check("ovr_sticky", ovr4, 1);
      check("ovr_latency", lat_bad, 0);

      // Reset asserted while the sample sits in MULT.
      @(negedge clk_i); sample_i = 16'sd3000; sample_valid_i = 1'b1;
      @(posedge clk_i); #1; sample_valid_i = 1'b0;
      repeat (3) @(posedge clk_i); #1;
      check("mid_busy", busy4, 1);
      rst_n_i = 1'b0;
      #1;
      check("mid_sample_o", so4, 0);
      check("mid_valid", sv4, 0);
      check("mid_busy_rst", busy4, 0);
      check("mid_overrun", ovr4, 0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) rst_n_i = 1'b1;
         @(posedge clk_i); #1;
         if (sv4 === 1'b1) pulses++;
      end
      check("mid_nostrobe", pulses, 0);
      for (int k = 0; k < 6; k++) begin
         send((k == 0) ? 500 : 0, 1'b0, 0, o4, o512);
         res[k] = o4;
      end
      check("mid_after_3", res[3], 0);
      check("mid_after_4", res[4], 500);
      check("mid_after_5", res[5], 0);

      // Fill and wrap at d=512 over 3000 samples.
      do_reset();
      lat_bad = 0; errs_zero = 0; errs_body = 0;
      for (int k = 0; k < 3000; k++) begin
         send(7 * k + 1, 1'b0, 0, o4, o512);
         expv = (k < 512) ? 0 : 7 * (k - 512) + 1;
         if (o512 != expv) begin
            if (k < 512) errs_zero++;
            else errs_body++;
         end
         if (k == 511)  s511  = o512;
         if (k == 512)  s512  = o512;
         if (k == 1024) s1024 = o512;
         if (k == 2048) s2048 = o512;
         if (k == 2999) slast = o512;
      end
      check("wrap_zero_region", errs_zero, 0);
      check("wrap_body_region", errs_body, 0);
      check("wrap_511", s511, 0);
      check("wrap_512", s512, 1);
      check("wrap_1024", s1024, 3585);
      check("wrap_2048", s2048, 10753);
      check("wrap_2999", slast, 17410);
      check("wrap_latency", lat_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
